// File: rtl/shared_rom_reader_pkg.sv
// Shared types, default widths and helpers for the shared ROM reader.
package shared_rom_reader_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NUM_REQ_DEF    = 4;
  localparam int NUM_PORTS_DEF  = 2;

  typedef logic [DATA_WIDTH_DEF-1:0] rom_data_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] rom_addr_t;

  // Round-robin pointer width; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // On-chip ROM image: word a holds 0x100 + a.
  function automatic logic [63:0] rom_image_word(input int unsigned a);
    return 64'h0000_0000_0000_0100 + 64'(a);
  endfunction

endpackage

// File: rtl/shared_rom_reader_rr_multi_arbiter.sv
// Combinational multi-grant round-robin arbiter: grants the first NUM_PORTS requests
// found scanning upward from the pointer, and reports which requester owns each port.
module shared_rom_reader_rr_multi_arbiter
  import shared_rom_reader_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int PTR_W     = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [PTR_W-1:0]                rr_ptr_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [PTR_W-1:0]                next_ptr_o,
  output logic [NUM_PORTS-1:0]            port_vld_o,
  output logic [NUM_PORTS-1:0][PTR_W-1:0] port_owner_o
);

  // Rotating scan; the n-th grant found is placed on port n.
  always_comb begin
    int         idx;
    int         taken;
    logic       take;
    logic [PTR_W-1:0] idx_w;
    gnt_o        = '0;
    next_ptr_o   = rr_ptr_i;
    port_vld_o   = '0;
    port_owner_o = '0;
    taken        = 0;
    idx          = 0;
    idx_w        = '0;
    take         = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx   = int'(rr_ptr_i) + j;
      idx   = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
      idx_w = PTR_W'(idx);
      take  = req_i[idx_w] && (taken < NUM_PORTS);
      gnt_o[idx_w] = take;
      for (int p = 0; p < NUM_PORTS; p++) begin
        port_vld_o[p]   = port_vld_o[p] | (take && (taken == p));
        port_owner_o[p] = (take && (taken == p)) ? idx_w : port_owner_o[p];
      end
      next_ptr_o = take ? ((idx + 1 == NUM_REQ) ? '0 : PTR_W'(idx + 1)) : next_ptr_o;
      taken      = take ? taken + 1 : taken;
    end
  end

endmodule

// File: rtl/shared_rom_reader.sv
// NUM_REQ requesters share NUM_PORTS synchronous ROM read ports; responses come back
// one cycle after the grant, routed to the requester that owned each port.
module shared_rom_reader
  import shared_rom_reader_pkg::*;
#(
  parameter int DATA_WIDTH = $bits(rom_data_t),
  parameter int ADDR_WIDTH = $bits(rom_addr_t),
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int NUM_PORTS  = NUM_PORTS_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   rsp_data
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0]                    rr_ptr_q;
  logic [PTR_W-1:0]                    rr_ptr_d;
  logic [NUM_REQ-1:0]                  arb_gnt_s;
  logic [NUM_PORTS-1:0]                arb_port_vld_s;
  logic [NUM_PORTS-1:0][PTR_W-1:0]     arb_owner_s;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_addr_s;
  logic [DATA_WIDTH-1:0]               rom_mem [DEPTH];
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_data_q;
  logic [NUM_PORTS-1:0]                port_vld_q;
  logic [NUM_PORTS-1:0][PTR_W-1:0]     port_owner_q;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  hold_q;
  logic [NUM_REQ-1:0]                  rsp_valid_s;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  rsp_data_s;

  shared_rom_reader_rr_multi_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_arb (
    .req_i        (req),
    .rr_ptr_i     (rr_ptr_q),
    .gnt_o        (arb_gnt_s),
    .next_ptr_o   (rr_ptr_d),
    .port_vld_o   (arb_port_vld_s),
    .port_owner_o (arb_owner_s)
  );

  assign gnt = reset ? '0 : arb_gnt_s;

  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    assign rom_mem[a] = DATA_WIDTH'(rom_image_word(a));
  end

  // Words beyond the populated depth read as zero.
  function automatic logic [DATA_WIDTH-1:0] rom_read(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) < DEPTH) ? rom_mem[a] : '0;
  endfunction

  // Crossbar: each port takes the address of the requester it was granted to.
  always_comb begin
    port_addr_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_addr_s[p] = req_addr[arb_owner_s[p]];
    end
  end

  // Control state: pointer, port-valid pipeline and per-requester held data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      port_vld_q <= '0;
      hold_q     <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      port_vld_q <= arb_port_vld_s;
      hold_q     <= rsp_data_s;
    end
  end

  // Registered ROM read per port and its owner index; only observed when port_vld_q is set.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_data_q[p]  <= rom_read(port_addr_s[p]);
      port_owner_q[p] <= arb_owner_s[p];
    end
  end

  // Demux port data back to the owning requesters; others keep their last value.
  always_comb begin
    logic sel;
    sel         = 1'b0;
    rsp_valid_s = '0;
    rsp_data_s  = hold_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        sel            = port_vld_q[p] && (port_owner_q[p] == PTR_W'(i));
        rsp_valid_s[i] = rsp_valid_s[i] | sel;
        rsp_data_s[i]  = sel ? port_data_q[p] : rsp_data_s[i];
      end
    end
  end

  assign rsp_valid = reset ? '0 : rsp_valid_s;
  assign rsp_data  = reset ? '0 : rsp_data_s;

endmodule

// File: tb/tb_shared_rom_reader.sv
// Randomised + directed bench for shared_rom_reader across four configurations,
// checked against a behavioural round-robin/ROM reference model.
module tb_shared_rom_reader;

  localparam int NDUT = 4;
  localparam int NR   = 4;

  function automatic int np_of(input int k);
    return (k == 2) ? 1 : ((k == 3) ? 3 : 2);
  endfunction

  function automatic int dep_of(input int k);
    return (k == 1) ? 20 : 32;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [3:0]           req_s  [NDUT];
  logic [3:0][4:0]      addr_s [NDUT];
  logic [3:0]           gnt_s  [NDUT];
  logic [3:0]           vld_s  [NDUT];
  logic [3:0][31:0]     data_s [NDUT];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    shared_rom_reader #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (5),
      .DEPTH      ((k == 1) ? 20 : 32),
      .NUM_REQ    (4),
      .NUM_PORTS  ((k == 2) ? 1 : ((k == 3) ? 3 : 2))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req_s[k]),
      .req_addr  (addr_s[k]),
      .gnt       (gnt_s[k]),
      .rsp_valid (vld_s[k]),
      .rsp_data  (data_s[k])
    );
  end

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state
  int          m_ptr  [NDUT];
  int          m_nptr [NDUT];
  logic [3:0]  m_gnt  [NDUT];
  logic [3:0]  m_vld  [NDUT];
  logic [31:0] m_dat  [NDUT][NR];
  int          m_wait [NDUT][NR];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rom_exp(input logic [4:0] a, input int depth);
    return (int'(a) < depth) ? (32'h100 + 32'(a)) : 32'h0;
  endfunction

  function automatic logic [3:0] model_gnt(input logic [3:0] r, input int ptr, input int np,
                                           output int nptr);
    logic [3:0] g;
    int taken;
    g = 4'b0000;
    taken = 0;
    nptr = ptr;
    for (int j = 0; j < NR; j++) begin
      int idx;
      idx = (ptr + j) % NR;
      if (r[idx] && taken < np) begin
        g[idx] = 1'b1;
        taken++;
        nptr = (idx + 1) % NR;
      end
    end
    return g;
  endfunction

  // One clock cycle: check outputs for current inputs, cross the edge, advance the model.
  task automatic tick();
    #1;
    for (int k = 0; k < NDUT; k++) begin
      int np;
      for (int i = 0; i < NR; i++) begin
        check_val($sformatf("d%0d_vld%0d", k, i), 32'(vld_s[k][i]), reset ? 32'd0 : 32'(m_vld[k][i]));
        check_val($sformatf("d%0d_dat%0d", k, i), data_s[k][i], reset ? 32'd0 : m_dat[k][i]);
      end
      m_gnt[k] = reset ? 4'b0000 : model_gnt(req_s[k], m_ptr[k], np_of(k), np);
      m_nptr[k] = np;
      check_val($sformatf("d%0d_gnt", k), 32'(gnt_s[k]), 32'(m_gnt[k]));
    end
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) begin
      int bound;
      bound = (NR + np_of(k) - 1) / np_of(k);
      if (reset) begin
        m_ptr[k] = 0;
        m_vld[k] = 4'b0000;
        for (int i = 0; i < NR; i++) begin
          m_dat[k][i]  = 32'h0;
          m_wait[k][i] = 0;
        end
      end else begin
        for (int i = 0; i < NR; i++) begin
          if (m_gnt[k][i]) begin
            m_vld[k][i]  = 1'b1;
            m_dat[k][i]  = rom_exp(addr_s[k][i], dep_of(k));
            m_wait[k][i] = 0;
          end else begin
            m_vld[k][i]  = 1'b0;
            m_wait[k][i] = m_wait[k][i] + int'(req_s[k][i]);
          end
          check_val($sformatf("d%0d_starve%0d", k, i), 32'(m_wait[k][i] < bound), 32'd1);
        end
        if (m_gnt[k] != 4'b0000) m_ptr[k] = m_nptr[k];
      end
    end
    #1;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < NDUT; k++) req_s[k] = 4'b0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] wrap_a;
    reset = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      req_s[k]  = 4'b0000;
      addr_s[k] = '0;
      m_ptr[k]  = 0;
      m_nptr[k] = 0;
      m_gnt[k]  = 4'b0000;
      m_vld[k]  = 4'b0000;
      for (int i = 0; i < NR; i++) begin
        m_dat[k][i]  = 32'h0;
        m_wait[k][i] = 0;
      end
    end
    tick();
    tick();
    reset = 1'b0;

    // Single request, address 5
    req_s[0] = 4'b0001;
    addr_s[0][0] = 5'd5;
    #1 check_val("t1_gnt", 32'(gnt_s[0]), 32'h1);
    tick();
    req_s[0] = 4'b0000;
    #1;
    check_val("t1_vld", 32'(vld_s[0]), 32'h1);
    check_val("t1_dat", data_s[0][0], 32'h105);
    tick();

    // All four requesting, two ports
    do_reset();
    req_s[0] = 4'b1111;
    for (int i = 0; i < NR; i++) addr_s[0][i] = 5'(i + 1);
    #1 check_val("t2_gnt_a", 32'(gnt_s[0]), 32'h3);
    tick();
    #1;
    check_val("t2_gnt_b", 32'(gnt_s[0]), 32'hC);
    check_val("t2_vld_b", 32'(vld_s[0]), 32'h3);
    check_val("t2_dat0", data_s[0][0], 32'h101);
    check_val("t2_dat1", data_s[0][1], 32'h102);
    tick();
    #1;
    check_val("t2_gnt_c", 32'(gnt_s[0]), 32'h3);
    check_val("t2_vld_c", 32'(vld_s[0]), 32'hC);
    check_val("t2_dat2", data_s[0][2], 32'h103);
    check_val("t2_dat3", data_s[0][3], 32'h104);
    tick();
    req_s[0] = 4'b0000;
    tick();

    // Address wrap-around and out-of-depth read
    wrap_a = 5'd0;
    wrap_a = wrap_a - 5'd1;
    req_s[0] = 4'b0010;
    addr_s[0][1] = wrap_a;
    req_s[1] = 4'b0010;
    addr_s[1][1] = 5'd25;
    tick();
    clear_reqs();
    #1;
    check_val("t3_wrap_dat", data_s[0][1], 32'h11F);
    check_val("t3_oor_vld", 32'(vld_s[1]), 32'h2);
    check_val("t3_oor_dat", data_s[1][1], 32'h0);
    tick();

    // Same address from two requesters
    req_s[0] = 4'b0101;
    addr_s[0][0] = 5'd7;
    addr_s[0][2] = 5'd7;
    #1 check_val("t4_gnt", 32'(gnt_s[0]), 32'h5);
    tick();
    req_s[0] = 4'b0000;
    #1;
    check_val("t4_vld", 32'(vld_s[0]), 32'h5);
    check_val("t4_dat0", data_s[0][0], 32'h107);
    check_val("t4_dat2", data_s[0][2], 32'h107);
    tick();

    // Reset right after a grant
    req_s[0] = 4'b0010;
    addr_s[0][1] = 5'd3;
    #1 check_val("t5_gnt_pre", 32'(gnt_s[0]), 32'h2);
    tick();
    reset = 1'b1;
    req_s[0] = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_val("t5_rst_gnt", 32'(gnt_s[0]), 32'h0);
      check_val("t5_rst_vld", 32'(vld_s[0]), 32'h0);
      check_val("t5_rst_dat", data_s[0][1], 32'h0);
      tick();
    end
    reset = 1'b0;
    req_s[0] = 4'b1110;
    #1;
    check_val("t5_post_gnt", 32'(gnt_s[0]), 32'h6);
    check_val("t5_post_vld", 32'(vld_s[0]), 32'h0);
    check_val("t5_post_dat", data_s[0][1], 32'h0);
    tick();
    req_s[0] = 4'b0000;
    #1;
    check_val("t5_rsp_vld", 32'(vld_s[0]), 32'h6);
    check_val("t5_rsp_dat1", data_s[0][1], 32'h103);
    check_val("t5_rsp_dat2", data_s[0][2], 32'h107);
    tick();

    // Randomised traffic on all configurations; requests held until granted
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < NDUT; k++) begin
        for (int i = 0; i < NR; i++) begin
          if (!req_s[k][i] || m_gnt[k][i]) begin
            req_s[k][i]  = ($urandom_range(0, 3) != 0);
            addr_s[k][i] = ($urandom_range(0, 3) == 0) ? 5'd7 : 5'($urandom_range(0, 31));
          end
        end
      end
      tick();
    end
    reset = 1'b0;
    clear_reqs();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
